// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC source select, stall/kill control
// and a circular return-address stack.
module fetch_sequencer #(
   parameter int RAS_DEPTH = 4,
   parameter int LU_STALL  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_req,
   input  logic        call_req,
   input  logic        branch_taken,
   input  logic        ret_req,
   input  logic        load_use,
   input  logic        mem_busy,
   input  logic [15:0] npc,
   output logic [1:0]  PCsrc,
   output logic        stall,
   output logic        kill,
   output logic [15:0] ReturnAddress,
   output logic        ras_empty,
   output logic [1:0]  ras_err
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] STALL = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   logic [1:0]    state, state_n;
   logic [2:0]    cnt, cnt_n;
   logic          lu_mask, lu_mask_n;
   logic [1:0]    pc_c;
   logic          stall_c, kill_c;
   logic          push, pop;
   logic [15:0]   ras [RAS_DEPTH];
   logic [PW-1:0] ptr, ptr_inc, ptr_dec;
   logic [CW-1:0] count;
   logic [15:0]   ras_top;

   assign ptr_inc = ptr + PW'(1);
   assign ptr_dec = ptr - PW'(1);
   assign ras_top = (count == '0) ? 16'h0000 : ras[ptr];

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      lu_mask_n = 1'b0;
      pc_c      = 2'd0;
      stall_c   = 1'b0;
      kill_c    = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      if (mem_busy) begin
         stall_c   = 1'b1;
         kill_c    = (state == FLUSH);
         lu_mask_n = lu_mask;
      end else begin
         case (state)
            RUN: begin
               if (load_use && !lu_mask) begin
                  stall_c = 1'b1;
                  cnt_n   = 3'(LU_STALL - 1);
                  if (LU_STALL == 1) lu_mask_n = 1'b1;
                  else state_n = STALL;
               end else if (ret_req) begin
                  pc_c    = 2'd3;
                  kill_c  = 1'b1;
                  pop     = 1'b1;
                  state_n = FLUSH;
               end else if (branch_taken) begin
                  pc_c    = 2'd2;
                  kill_c  = 1'b1;
                  state_n = FLUSH;
               end else if (call_req || jump_req) begin
                  pc_c    = 2'd1;
                  kill_c  = 1'b1;
                  push    = call_req;
                  state_n = FLUSH;
               end
            end
            STALL: begin
               stall_c = 1'b1;
               cnt_n   = cnt - 3'd1;
               // same load is still in ID on exit; do not re-stall on it
               if (cnt_n == 3'd0) begin
                  state_n   = RUN;
                  lu_mask_n = 1'b1;
               end
            end
            FLUSH: begin
               kill_c  = 1'b1;
               state_n = RUN;
            end
            default: state_n = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         cnt     <= 3'd0;
         lu_mask <= 1'b0;
         ptr     <= '0;
         count   <= '0;
         ras_err <= 2'b00;
         for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= 16'h0000;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         lu_mask <= lu_mask_n;
         if (push) begin
            ptr          <= ptr_inc;
            ras[ptr_inc] <= npc;
            if (count == CW'(RAS_DEPTH)) ras_err[1] <= 1'b1;
            else count <= count + CW'(1);
         end else if (pop) begin
            if (count == '0) begin
               ras_err[0] <= 1'b1;
            end else begin
               ptr   <= ptr_dec;
               count <= count - CW'(1);
            end
         end
      end
   end

   assign PCsrc         = rst ? 2'd0 : pc_c;
   assign stall         = rst ? 1'b0 : stall_c;
   assign kill          = rst ? 1'b0 : kill_c;
   assign ReturnAddress = rst ? 16'h0000 : ras_top;
   assign ras_empty     = rst | (count == '0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer
// (RAS_DEPTH=4, LU_STALL=2).
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst, jump_req, call_req, branch_taken;
   logic        ret_req, load_use, mem_busy;
   logic [15:0] npc;
   logic [1:0]  PCsrc;
   logic        stall, kill;
   logic [15:0] ReturnAddress;
   logic        ras_empty;
   logic [1:0]  ras_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.RAS_DEPTH(4), .LU_STALL(2)) dut (
      .clk(clk), .rst(rst),
      .jump_req(jump_req), .call_req(call_req),
      .branch_taken(branch_taken), .ret_req(ret_req),
      .load_use(load_use), .mem_busy(mem_busy),
      .npc(npc), .PCsrc(PCsrc), .stall(stall),
      .kill(kill), .ReturnAddress(ReturnAddress),
      .ras_empty(ras_empty), .ras_err(ras_err)
   );

   typedef struct {
      logic        r, j, c, b, t, l, m;
      logic [15:0] n;
      logic [1:0]  pc;
      logic        st, kl;
      logic [15:0] ra;
      logic        em;
      logic [1:0]  er;
      logic        ce;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic r, j, c, b, t, l, m,
      input logic [15:0] n,
      input logic [1:0] pc,
      input logic st, kl,
      input logic [15:0] ra,
      input logic em,
      input logic [1:0] er,
      input logic ce);
      vec_t v;
      v.r = r; v.j = j; v.c = c; v.b = b;
      v.t = t; v.l = l; v.m = m; v.n = n;
      v.pc = pc; v.st = st; v.kl = kl;
      v.ra = ra; v.em = em; v.er = er; v.ce = ce;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h",
                  nm, idx, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      rst = v.r; jump_req = v.j; call_req = v.c;
      branch_taken = v.b; ret_req = v.t;
      load_use = v.l; mem_busy = v.m; npc = v.n;
      #4;
      chk("PCsrc", idx, 16'(PCsrc), 16'(v.pc));
      chk("stall", idx, 16'(stall), 16'(v.st));
      chk("kill", idx, 16'(kill), 16'(v.kl));
      chk("ReturnAddress", idx, ReturnAddress, v.ra);
      chk("ras_empty", idx, 16'(ras_empty), 16'(v.em));
      if (v.ce) chk("ras_err", idx, 16'(ras_err), 16'(v.er));
      @(posedge clk);
      #1;
   endtask

   task automatic step(
      input logic r, j, c, b, t, l, m,
      input logic [15:0] n,
      input logic [1:0] pc,
      input logic st, kl,
      input logic [15:0] ra,
      input logic em,
      input logic [1:0] er,
      input int idx);
      run_vec(mk(r, j, c, b, t, l, m, n,
                 pc, st, kl, ra, em, er, 1'b1), idx);
   endtask

   initial begin
      rst = 1'b1; jump_req = 1'b0; call_req = 1'b0;
      branch_taken = 1'b0; ret_req = 1'b0;
      load_use = 1'b0; mem_busy = 1'b0; npc = 16'h0;

      // reset overrides inputs, then idle
      tbl.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0,0,1,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,1));
      // load-use: two stall cycles
      tbl.push_back(mk(0,0,0,0,0,1,0,0, 0,1,0,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,1,0,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,1));
      // branch beats jump; held jump squashed in FLUSH
      tbl.push_back(mk(0,1,0,1,0,0,0,0, 2,0,1,0,1,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,0,0, 0,0,1,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,1));
      // call then ret
      tbl.push_back(mk(0,0,1,0,0,0,0,16'h10,
                       1,0,1,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,
                       0,0,1,16'h10,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0,0,
                       3,0,1,16'h10,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,1,0,1));
      // stall beats ret; ret accepted after stall
      tbl.push_back(mk(0,0,0,0,1,1,0,0, 0,1,0,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0,0, 0,1,0,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0,0, 3,0,1,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,1,1,1));
      // five calls into a four-entry stack
      for (int k = 1; k <= 5; k++) begin
         tbl.push_back(mk(0,0,1,0,0,0,0,16'(k),
            1,0,1,(k == 1) ? 16'h0 : 16'(k - 1),
            (k == 1), 2'b01, 1));
         tbl.push_back(mk(0,0,0,0,0,0,0,0,
            0,0,1,16'(k),0,(k == 5) ? 2'b11 : 2'b01, 1));
      end
      for (int k = 5; k >= 2; k--) begin
         tbl.push_back(mk(0,0,0,0,1,0,0,0,
            3,0,1,16'(k),0,2'b11,1));
         tbl.push_back(mk(0,0,0,0,0,0,0,0,
            0,0,1,(k == 2) ? 16'h0 : 16'(k - 1),
            (k == 2), 2'b11, 1));
      end
      tbl.push_back(mk(0,0,0,0,1,0,0,0, 3,0,1,0,1,3,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,1,3,1));
      // reset in STALL and in FLUSH
      tbl.push_back(mk(0,0,0,0,0,1,0,0, 0,1,0,0,1,3,1));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,0,0, 1,0,1,0,1,0,1));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,1));

      @(posedge clk);
      #1;
      foreach (tbl[i]) run_vec(tbl[i], i);

      // mem_busy holds a pending ret, then it is taken once
      step(0,0,1,0,0,0,0,16'h42, 1,0,1,16'h0,1,0, 100);
      step(0,0,0,0,0,0,0,16'h0, 0,0,1,16'h42,0,0, 101);
      for (int i = 0; i < 3; i++)
         step(0,0,0,0,1,0,1,16'h0,
              0,1,0,16'h42,0,0, 102 + i);
      step(0,0,0,0,1,0,0,16'h0, 3,0,1,16'h42,0,0, 105);
      step(0,0,0,0,1,0,0,16'h0, 0,0,1,16'h0,1,0, 106);
      step(0,0,0,0,0,0,0,16'h0, 0,0,0,16'h0,1,0, 107);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RAS_DEPTH, 4, return-address-stack entries (power of two, 2..16).
REQ-002 Parameter: LU_STALL, 1, cycles IF is frozen per accepted load-use hazard (1..7).
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: jump_req  in  1  J-type jump resolved in ID.
REQ-006 Port: call_req  in  1  jump-and-link in ID; treated as jump plus RAS push.
REQ-007 Port: branch_taken  in  1  I-type branch resolved taken in ID.
REQ-008 Port: ret_req  in  1  return instruction in ID.
REQ-009 Port: load_use  in  1  load-use hazard detected in ID.
REQ-010 Port: mem_busy  in  1  instruction memory not ready this cycle.
REQ-011 Port: npc  in  16  PC+1 of the instruction in ID; value pushed on call.
REQ-012 Port: PCsrc  out  2  0 sequential, 1 J-immediate, 2 I-immediate, 3 ReturnAddress.
REQ-013 Port: stall  out  1  freeze PC/IF register.
REQ-014 Port: kill  out  1  replace fetched instruction with NOP.
REQ-015 Port: ReturnAddress  out  16  RAS top entry; 16'h0000 when empty.
REQ-016 Port: ras_empty  out  1  RAS count is zero.
REQ-017 Port: ras_err  out  2  sticky {overflow, underflow} flags.

Function
REQ-018 FSM states RUN, STALL, FLUSH; PCsrc, stall, kill combinational from state and inputs.
REQ-019 RUN, load_use=1: stall=1, PCsrc=0, kill=0, counter loaded LU_STALL-1, go to STALL (or stay in RUN when LU_STALL=1, with load_use masked on the next cycle).
REQ-020 STALL: stall=1, PCsrc=0, kill=0; counter decrements per cycle; at 0 go to RUN; load_use ignored while in STALL.
REQ-021 mem_busy=1 in any state: stall=1, PCsrc=0, FSM state, counter and RAS held (no transition).
REQ-022 RUN, no stall condition: redirect priority ret_req > branch_taken > call_req/jump_req; winner drives PCsrc 3/2/1 and kill=1 that cycle; go to FLUSH.
REQ-023 FLUSH: kill=1, PCsrc=0, stall=0 for exactly one cycle, then RUN; all redirect requests ignored (squashed instruction).
REQ-024 Stall conditions take priority over redirects; a redirect present during stall is not accepted until RUN with no stall.
REQ-025 RAS push on accepted call_req: entry[top+1] <= npc, count increments, saturating at RAS_DEPTH.
REQ-026 Push when full: oldest entry overwritten (circular pointer), count stays RAS_DEPTH, overflow flag set.
REQ-027 RAS pop on accepted ret_req: ReturnAddress presents top in same cycle; pointer/count decrement at clock edge.
REQ-028 Pop when empty: PCsrc=3, ReturnAddress=0, count stays 0, underflow flag set.
REQ-029 Only the winning request of REQ-022 updates the RAS; losing call_req does not push.
REQ-030 Pointer arithmetic modulo RAS_DEPTH; count width clog2(RAS_DEPTH)+1.
REQ-031 ras_err flags clear only on rst.

Reset
REQ-032 rst=1 at clock edge: state RUN, counter 0, RAS count 0, pointer 0, ras_err 00, all entries 0.
REQ-033 While rst=1: PCsrc=0, stall=0, kill=0, ReturnAddress=0, ras_empty=1, regardless of other inputs.
REQ-034 rst asserted in STALL or FLUSH: next cycle RUN with no residual stall or kill.

Verification
REQ-035 Reset, then idle 3 cycles -> PCsrc=0, stall=0, kill=0, ras_empty=1, ras_err=00.
REQ-036 LU_STALL=2, load_use pulse 1 cycle in RUN -> stall=1 for 2 cycles, then stall=0, PCsrc=0.
REQ-037 branch_taken and jump_req same cycle -> PCsrc=2, kill=1; next cycle kill=1, PCsrc=0; jump_req held high is ignored in FLUSH.
REQ-038 call_req npc=16'h0010, FLUSH, ret_req -> PCsrc=3, ReturnAddress=16'h0010, ras_empty=1 after edge.
REQ-039 RAS_DEPTH=4, five calls npc=1..5 then five rets -> ReturnAddress 5,4,3,2 then 0; ras_err=11.
REQ-040 mem_busy=1 concurrent with ret_req for 3 cycles -> stall=1, RAS unchanged; on mem_busy=0, PCsrc=3 accepted once.
